btn_hex_tx_ctrl: RTL and testbench
==================================

Name: btn_hex_tx_ctrl

Overview:
- Consumes the one-cycle debounced button tick and the 8-bit switch value. On each tick it captures the switch value.
- Each captured byte goes into a small FIFO. Bytes are drained in order and sent to the UART transmitter as uppercase ASCII hex, optionally followed by CR LF.
- Sits between the button debouncer and the UART TX block. Handshake to TX is start-pulse / done-tick.

Parameters:
- DEPTH, 4, FIFO depth in captured bytes; power of 2, minimum 2.
- APPEND_CRLF, 1, 1 = each byte is sent as 4 characters (hi hex, lo hex, 0x0D, 0x0A); 0 = only the 2 hex characters are sent.

Ports:
- clk_100MHz  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- db_tick  in  1  one-cycle pulse from the debouncer; requests capture of sw.
- sw  in  8  byte to capture; sampled in the cycle db_tick is high.
- tx_done_tick  in  1  one-cycle pulse from UART TX; the current character has finished.
- tx_start  out  1  one-cycle pulse; UART TX loads tx_data.
- tx_data  out  8  ASCII character; held stable from the tx_start cycle until the tx_done_tick cycle.
- busy  out  1  high whenever the FSM is not IDLE.
- fifo_count  out  $clog2(DEPTH)+1  number of bytes queued, not counting the byte currently being sent.
- overflow  out  1  sticky; set when a tick is dropped because the FIFO is full.

Behaviour:
- Reset (synchronous, active-high, clk_100MHz):
  - FSM goes to IDLE; FIFO pointers and count go to 0.
  - tx_start=0, tx_data=0x00, busy=0, overflow=0.
  - Reset mid-frame aborts the frame immediately; no further tx_start is issued. A tx_done_tick arriving after reset is ignored.
- FIFO:
  - Push: db_tick=1 and count<DEPTH writes sw at the write pointer.
  - Drop: db_tick=1 and count==DEPTH discards sw and sets overflow. Only reset clears overflow.
  - Pop: occurs only in IDLE when count>0.
  - Push and pop in the same cycle leave count unchanged and both pointers advance. This case is legal even when the FIFO is full, because the pop frees a slot in that same cycle.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, SEND, WAIT. Character index idx is 2 bits.
  - IDLE, count>0: pop head into byte_reg, set idx=0, go to SEND. Otherwise stay.
  - SEND: tx_start=1 for exactly this cycle; tx_data=char(idx) is registered on entry. Go to WAIT.
  - WAIT: on tx_done_tick:
    - If idx is the last index (3 when APPEND_CRLF=1, else 1): go to IDLE.
    - Otherwise idx=idx+1 and go to SEND.
    - With no tx_done_tick, stay in WAIT indefinitely; there is no timeout.
  - A tx_done_tick seen in IDLE or SEND is ignored.
- Character encoding, for nibble n:
  - n<10: 0x30+n.
  - n≥10: 0x37+n (uppercase A-F).
  - idx 0 = hi nibble, idx 1 = lo nibble, idx 2 = 0x0D, idx 3 = 0x0A.
- Latency:
  - db_tick in cycle T with FIFO empty and FSM in IDLE: FIFO written at end of T, pop in T+1, tx_start in T+2.
  - tx_done_tick in cycle U (not last char): next tx_start in U+1.
  - Last char done in U: FSM is in IDLE in U+1. If count>0, pop in U+1 and tx_start in U+2.
- db_tick is accepted in any FSM state. Capture never stalls transmission.
- tx_data keeps its last value in IDLE.

Test Plan:
- APPEND_CRLF=1; reset, then db_tick with sw=0x5A -> tx_start at T+2 with tx_data=0x35. Each subsequent tx_start comes 1 cycle after a tx_done_tick, with data 0x41, 0x0D, 0x0A. busy drops 1 cycle after the 4th tx_done_tick.
- sw=0x09 then sw=0xF0, back-to-back ticks during the first frame -> streams 0x30,0x39,0x0D,0x0A then 0x46,0x30,0x0D,0x0A. fifo_count peaks at 1 (second byte queued while first is in flight). No gap beyond 1 IDLE cycle between frames.
- DEPTH=4; hold TX (no tx_done_tick) and issue 6 ticks -> 1 byte in flight, fifo_count=4, the 6th tick sets overflow=1. Releasing done ticks delivers exactly 5 frames; overflow stays 1.
- FIFO full, db_tick coincides with the IDLE pop cycle -> the byte is accepted, count stays 4, overflow is unchanged.
- Assert reset while in WAIT on char idx 1 -> next cycle busy=0, tx_start=0, fifo_count=0. A later tx_done_tick produces no tx_start.
- APPEND_CRLF=0, sw=0xC3 -> exactly 2 tx_start pulses with 0x43, 0x33, then IDLE.

Source files
------------

// File: rtl/btn_hex_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : btn_hex_tx_ctrl
// Purpose  : Queues button-captured switch bytes and sends them to a UART TX
//            as uppercase ASCII hex, optionally followed by CR LF.
// Revision : 1.0
// ============================================================================
module btn_hex_tx_ctrl #(
  parameter int DEPTH       = 4,
  parameter bit APPEND_CRLF = 1'b1
) (
  input  logic                     clk_100MHz,
  input  logic                     reset,
  input  logic                     db_tick,
  input  logic [7:0]               sw,
  input  logic                     tx_done_tick,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int              c_AW       = $clog2(DEPTH);
  localparam logic [1:0]      c_LAST_IDX = APPEND_CRLF ? 2'd3 : 2'd1;
  localparam logic [c_AW:0]   c_FULL     = (c_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_mem [DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_AW:0]     r_count;
  logic [7:0]        r_byte;
  logic [1:0]        r_idx;
  logic [7:0]        r_tx_data;
  logic              r_overflow;

  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic              w_load;
  logic [1:0]        w_idx_nxt;
  logic [7:0]        w_byte_nxt;

  function automatic logic [7:0] f_hex(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  function automatic logic [7:0] f_char(input logic [7:0] b, input logic [1:0] idx);
    case (idx)
      2'd0:    return f_hex(b[7:4]);
      2'd1:    return f_hex(b[3:0]);
      2'd2:    return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_idx_nxt   = r_idx;
    w_byte_nxt  = r_byte;
    tx_start    = 1'b0;
    busy        = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_load      = 1'b1;
          w_idx_nxt   = 2'd0;
          w_byte_nxt  = r_mem[r_rd_ptr];
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        tx_start    = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done_tick) begin
          if (r_idx == c_LAST_IDX) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_load      = 1'b1;
            w_idx_nxt   = r_idx + 2'd1;
            w_state_nxt = S_SEND;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the tick.
  assign w_push = db_tick && ((r_count != c_FULL) || w_pop);
  assign w_drop = db_tick && !w_push;

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_byte     <= 8'h00;
      r_idx      <= 2'd0;
      r_tx_data  <= 8'h00;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      if (w_load) begin
        r_byte    <= w_byte_nxt;
        r_idx     <= w_idx_nxt;
        r_tx_data <= f_char(w_byte_nxt, w_idx_nxt);
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (w_push) r_mem[r_wr_ptr] <= sw;
  end

  assign tx_data    = r_tx_data;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_btn_hex_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_hex_tx_ctrl
// Purpose  : Scoreboard bench for btn_hex_tx_ctrl (CRLF and hex-only builds).
// Revision : 1.0
// ============================================================================
module tb_btn_hex_tx_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       db_tick1, db_tick0;
  logic [7:0] sw1, sw0;
  logic       auto_done, man_done, auto_en;
  wire        tx_done_tick = auto_done | man_done;

  logic       tx_start1, tx_start0, busy1, busy0, overflow1, overflow0;
  logic [7:0] tx_data1, tx_data0;
  logic [2:0] fifo_count1, fifo_count0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int starts1 = 0, starts0 = 0;
  int busy_fall = -1;
  int peak = 0;
  int pos1 = 0;
  int pend = 0, dly = 0;
  logic prev_busy1 = 1'b0;
  logic [7:0] e1, e0;
  int t0, s_cnt;

  logic [7:0] exp_q1[$];
  logic [7:0] exp_q0[$];
  int         st_cyc[$];
  int         dn_cyc[$];

  btn_hex_tx_ctrl #(.DEPTH(4), .APPEND_CRLF(1'b1)) u_dut1 (
    .clk_100MHz(clk), .reset(reset), .db_tick(db_tick1), .sw(sw1),
    .tx_done_tick(tx_done_tick), .tx_start(tx_start1), .tx_data(tx_data1),
    .busy(busy1), .fifo_count(fifo_count1), .overflow(overflow1)
  );

  btn_hex_tx_ctrl #(.DEPTH(4), .APPEND_CRLF(1'b0)) u_dut0 (
    .clk_100MHz(clk), .reset(reset), .db_tick(db_tick0), .sw(sw0),
    .tx_done_tick(tx_done_tick), .tx_start(tx_start0), .tx_data(tx_data0),
    .busy(busy0), .fifo_count(fifo_count0), .overflow(overflow0)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected characters whenever a DUT issues tx_start.
  initial begin
    forever begin
      @(negedge clk);
      if (prev_busy1 && !busy1) busy_fall = cyc;
      prev_busy1 = busy1;
      if (int'(fifo_count1) > peak) peak = int'(fifo_count1);
      if (reset) pos1 = 0;
      if (tx_start1) begin
        st_cyc.push_back(cyc);
        starts1++;
        if (pos1 != 0 && dn_cyc.size() > 0)
          check("dut1_done_to_start", cyc - dn_cyc[$], 1);
        pos1 = (pos1 + 1) % 4;
        if (exp_q1.size() == 0) begin
          total++; bad++;
          $display("FAIL dut1_extra_start: got data 0x%0h expected no tx_start", tx_data1);
        end else begin
          e1 = exp_q1.pop_front();
          check("dut1_tx_data", int'(tx_data1), int'(e1));
        end
      end
      if (tx_start0) begin
        starts0++;
        if (exp_q0.size() == 0) begin
          total++; bad++;
          $display("FAIL dut0_extra_start: got data 0x%0h expected no tx_start", tx_data0);
        end else begin
          e0 = exp_q0.pop_front();
          check("dut0_tx_data", int'(tx_data0), int'(e0));
        end
      end
    end
  end

  // UART TX stand-in: done tick three cycles after each start when enabled.
  initial begin
    auto_done = 1'b0;
    forever begin
      @(negedge clk);
      auto_done = 1'b0;
      if (reset) pend = 0;
      else if (tx_start1 || tx_start0) begin
        pend = 1; dly = 0;
      end else if (pend != 0 && auto_en) begin
        dly++;
        if (dly == 3) begin
          auto_done = 1'b1;
          pend = 0;
          dn_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick1(input logic [7:0] v);
    db_tick1 = 1'b1; sw1 = v;
    @(negedge clk);
    db_tick1 = 1'b0;
  endtask

  task automatic pulse_done();
    man_done = 1'b1;
    dn_cyc.push_back(cyc);
    @(negedge clk);
    man_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while ((exp_q1.size() != 0 || exp_q0.size() != 0 || busy1 || busy0 ||
            fifo_count1 != 0 || fifo_count0 != 0) && n < max) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", (n < max) ? 1 : 0, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; db_tick1 = 1'b0; db_tick0 = 1'b0; sw1 = 8'h00; sw0 = 8'h00;
    man_done = 1'b0; auto_en = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_tx_start", tx_start1, 0);
    check("rst_tx_data", tx_data1, 8'h00);
    check("rst_busy", busy1, 0);
    check("rst_fifo_count", fifo_count1, 0);
    check("rst_overflow", overflow1, 0);

    // Single byte 0x5A with CR LF
    auto_en = 1'b1;
    st_cyc.delete(); dn_cyc.delete();
    exp_q1.push_back(8'h35); exp_q1.push_back(8'h41);
    exp_q1.push_back(8'h0D); exp_q1.push_back(8'h0A);
    t0 = cyc;
    tick1(8'h5A);
    wait_drain(200);
    check("t1_num_starts", st_cyc.size(), 4);
    if (st_cyc.size() > 0) check("t1_first_latency", st_cyc[0] - t0, 2);
    if (dn_cyc.size() >= 4) check("t1_busy_drop", busy_fall - dn_cyc[3], 1);
    check("t1_tx_data_held", tx_data1, 8'h0A);

    // Back-to-back 0x09, 0xF0
    st_cyc.delete(); dn_cyc.delete(); peak = 0;
    exp_q1.push_back(8'h30); exp_q1.push_back(8'h39);
    exp_q1.push_back(8'h0D); exp_q1.push_back(8'h0A);
    exp_q1.push_back(8'h46); exp_q1.push_back(8'h30);
    exp_q1.push_back(8'h0D); exp_q1.push_back(8'h0A);
    tick1(8'h09);
    tick1(8'hF0);
    wait_drain(300);
    check("t2_fifo_peak", peak, 1);
    check("t2_num_starts", st_cyc.size(), 8);
    if (st_cyc.size() >= 5 && dn_cyc.size() >= 4)
      check("t2_frame_gap", st_cyc[4] - dn_cyc[3], 2);

    // Overflow: TX held, six ticks
    auto_en = 1'b0;
    st_cyc.delete();
    for (int i = 1; i <= 5; i++) begin
      exp_q1.push_back(8'h30 + 8'(i)); exp_q1.push_back(8'h30 + 8'(i));
      exp_q1.push_back(8'h0D);         exp_q1.push_back(8'h0A);
    end
    tick1(8'h11); tick1(8'h22); tick1(8'h33); tick1(8'h44); tick1(8'h55);
    repeat (2) @(negedge clk);
    check("t3_count_full", fifo_count1, 4);
    check("t3_no_ovf_yet", overflow1, 0);
    check("t3_busy", busy1, 1);
    tick1(8'h66);
    check("t3_ovf_set", overflow1, 1);
    check("t3_count_still_full", fifo_count1, 4);
    auto_en = 1'b1;
    wait_drain(2000);
    check("t3_num_starts", st_cyc.size(), 20);
    check("t3_ovf_sticky", overflow1, 1);

    // Full FIFO, tick in the IDLE pop cycle
    do_reset();
    check("t4_ovf_cleared", overflow1, 0);
    auto_en = 1'b0;
    st_cyc.delete();
    exp_q1.push_back(8'h41); exp_q1.push_back(8'h30); exp_q1.push_back(8'h0D); exp_q1.push_back(8'h0A);
    exp_q1.push_back(8'h42); exp_q1.push_back(8'h31); exp_q1.push_back(8'h0D); exp_q1.push_back(8'h0A);
    exp_q1.push_back(8'h43); exp_q1.push_back(8'h32); exp_q1.push_back(8'h0D); exp_q1.push_back(8'h0A);
    exp_q1.push_back(8'h44); exp_q1.push_back(8'h33); exp_q1.push_back(8'h0D); exp_q1.push_back(8'h0A);
    exp_q1.push_back(8'h45); exp_q1.push_back(8'h34); exp_q1.push_back(8'h0D); exp_q1.push_back(8'h0A);
    exp_q1.push_back(8'h46); exp_q1.push_back(8'h35); exp_q1.push_back(8'h0D); exp_q1.push_back(8'h0A);
    tick1(8'hA0); tick1(8'hB1); tick1(8'hC2); tick1(8'hD3); tick1(8'hE4);
    repeat (2) @(negedge clk);
    check("t4_count_full", fifo_count1, 4);
    pulse_done(); pulse_done(); pulse_done();
    man_done = 1'b1;
    dn_cyc.push_back(cyc);
    @(negedge clk);
    man_done = 1'b0;
    db_tick1 = 1'b1; sw1 = 8'hF5;
    @(negedge clk);
    db_tick1 = 1'b0;
    check("t4_count_after_pushpop", fifo_count1, 4);
    check("t4_no_ovf", overflow1, 0);
    check("t4_next_frame_start", tx_start1, 1);
    auto_en = 1'b1;
    wait_drain(3000);
    check("t4_num_starts", st_cyc.size(), 24);
    check("t4_no_ovf_end", overflow1, 0);

    // Reset while waiting on character idx 1
    do_reset();
    auto_en = 1'b0;
    exp_q1.push_back(8'h37); exp_q1.push_back(8'h45);
    tick1(8'h7E);
    tick1(8'h12);
    repeat (3) @(negedge clk);
    pulse_done();
    check("t5_count_before", fifo_count1, 1);
    check("t5_busy_before", busy1, 1);
    s_cnt = starts1;
    reset = 1'b1;
    @(negedge clk);
    check("t5_busy_after", busy1, 0);
    check("t5_start_after", tx_start1, 0);
    check("t5_count_after", fifo_count1, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    pulse_done();
    repeat (10) @(negedge clk);
    check("t5_no_new_start", starts1 - s_cnt, 0);
    check("t5_exp_consumed", exp_q1.size(), 0);
    check("t5_still_idle", busy1, 0);

    // Hex-only build
    auto_en = 1'b1;
    s_cnt = starts0;
    exp_q0.push_back(8'h43); exp_q0.push_back(8'h33);
    db_tick0 = 1'b1; sw0 = 8'hC3;
    @(negedge clk);
    db_tick0 = 1'b0;
    wait_drain(200);
    check("t6_num_starts", starts0 - s_cnt, 2);
    check("t6_idle", busy0, 0);
    check("t6_data_held", tx_data0, 8'h33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
